reflection_var_responder: RTL



---
 rtl/reflection_var_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/reflection_var_responder.sv
// Reflection get/set responder. Owns a bank of variable registers that the host reads and
// writes one request at a time, while the design side writes them through a direct port.
module reflection_var_responder #(
  parameter int                  NUM_VARS = 16,
  parameter int                  DATA_W   = 32,
  parameter int                  IDX_W    = 8,
  parameter int                  TAG_W    = 4,
  parameter logic [NUM_VARS-1:0] RO_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_op,
  input  logic [IDX_W-1:0]             req_idx,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [TAG_W-1:0]             req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic [TAG_W-1:0]             rsp_tag,
  input  logic                         hw_we,
  input  logic [IDX_W-1:0]             hw_idx,
  input  logic [DATA_W-1:0]            hw_wdata,
  output logic [NUM_VARS*DATA_W-1:0]   vars_q,
  output logic [7:0]                   collision_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic                         op_q, op_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DATA_W-1:0]            wdata_q, wdata_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         req_ready_q, req_ready_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;
  logic                         rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0]             rsp_tag_q, rsp_tag_d;
  logic [NUM_VARS*DATA_W-1:0]   bank_q, bank_d;
  logic [7:0]                   collision_q, collision_d;

  logic                         req_fire;
  logic                         acc_hit;
  logic                         acc_ro;
  logic [DATA_W-1:0]            acc_val;
  logic                         set_wr;
  logic                         hw_drop;

  assign req_fire = (state_q == ST_IDLE) && req_valid && req_ready_q;

  // State register and all output/data flops; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      bank_q      <= '0;
      collision_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      tag_q       <= tag_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      bank_q      <= bank_d;
      collision_q <= collision_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) state_d = ST_ACCESS;
        else          state_d = ST_IDLE;
      end
      ST_ACCESS: state_d = ST_RESPOND;
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
        else           state_d = ST_RESPOND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and indexed lookup of the latched variable.
  always_comb begin
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    if (req_fire) begin
      op_d    = req_op;
      idx_d   = req_idx;
      wdata_d = req_wdata;
      tag_d   = req_tag;
    end else begin
      op_d    = op_q;
    end
    acc_hit = 1'b0;
    acc_ro  = 1'b0;
    acc_val = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      acc_hit = acc_hit | (idx_q == IDX_W'(i));
      acc_ro  = acc_ro  | ((idx_q == IDX_W'(i)) & RO_MASK[i]);
      acc_val = acc_val | ({DATA_W{idx_q == IDX_W'(i)}} & bank_q[i*DATA_W +: DATA_W]);
    end
  end

  assign set_wr  = (state_q == ST_ACCESS) && op_q && acc_hit && !acc_ro;
  assign hw_drop = hw_we && set_wr && (hw_idx == idx_q);

  // Output/response register next values; response fields only change in ACCESS.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESPOND);
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;
    if (state_q == ST_ACCESS) begin
      rsp_data_d = acc_hit ? acc_val : '0;
      rsp_err_d  = !acc_hit || (op_q && acc_ro);
      rsp_tag_d  = tag_q;
    end else begin
      rsp_tag_d  = rsp_tag_q;
    end
  end

  // Variable bank update: a host set beats a same-cycle hardware write to the same slot.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (set_wr && (idx_q == IDX_W'(i))) begin
        bank_d[i*DATA_W +: DATA_W] = wdata_q;
      end else if (hw_we && (hw_idx == IDX_W'(i))) begin
        bank_d[i*DATA_W +: DATA_W] = hw_wdata;
      end else begin
        bank_d[i*DATA_W +: DATA_W] = bank_q[i*DATA_W +: DATA_W];
      end
    end
    if (hw_drop && (collision_q != 8'd255)) collision_d = collision_q + 8'd1;
    else                                    collision_d = collision_q;
  end

  assign req_ready     = req_ready_q & ~rst;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_tag       = rsp_tag_q;
  assign vars_q        = bank_q;
  assign collision_cnt = collision_q;

endmodule
